// File: rtl/stereo_frame_assembler.sv
// ---------------------------------------------------------------------------
// stereo_frame_assembler
//
// Purpose:
//   Pairs each left sample from the serial audio decoder with the right
//   sample that follows it. Both samples are truncated to OUT_WIDTH MSBs.
//   Complete {left, right} frames are queued in a small FIFO and presented
//   downstream on a valid/ready interface. A decoder error or an out-of-order
//   L/R sequence discards the pending half-frame and resynchronises, so no
//   frame is ever emitted with its channels swapped or mismatched.
//
// Ports:
//   sclk         bit clock, rising-edge active
//   reset_n      asynchronous active-low reset
//   i_valid      sample valid from the decoder
//   i_ready      tied to 1, because the serial line cannot stall
//   i_is_left    1 = left sample, 0 = right sample
//   i_audio      left-justified 32-bit sample
//   i_error      decoder error level; takes priority over everything else
//   o_valid      FIFO head frame valid
//   o_ready      downstream accept
//   o_left       head frame, left channel
//   o_right      head frame, right channel
//   o_level      FIFO occupancy
//   o_overflow   sticky: a frame was dropped because the FIFO was full
//   o_sync_err   sticky: a pairing violation or error discard occurred
//   clear_flags  synchronous clear of both sticky flags (set wins)
// ---------------------------------------------------------------------------
module stereo_frame_assembler #(
  parameter int OUT_WIDTH  = 24,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            sclk,
  input  logic                            reset_n,
  input  logic                            i_valid,
  output logic                            i_ready,
  input  logic                            i_is_left,
  input  logic [31:0]                     i_audio,
  input  logic                            i_error,
  output logic                            o_valid,
  input  logic                            o_ready,
  output logic [OUT_WIDTH-1:0]            o_left,
  output logic [OUT_WIDTH-1:0]            o_right,
  output logic [$clog2(FIFO_DEPTH):0]     o_level,
  output logic                            o_overflow,
  output logic                            o_sync_err,
  input  logic                            clear_flags
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int FW = 2 * OUT_WIDTH;

  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [LW-1:0] CNT_ONE  = LW'(1);
  localparam logic [LW-1:0] CNT_FULL = LW'(FIFO_DEPTH);

  typedef enum logic {
    WAIT_LEFT  = 1'b0,
    WAIT_RIGHT = 1'b1
  } pairState_e;

  pairState_e stateQ, stateD;

  logic [OUT_WIDTH-1:0] heldLeftQ;
  logic [FW-1:0]        memQ [FIFO_DEPTH];
  logic [AW-1:0]        wrPtrQ, rdPtrQ;
  logic [LW-1:0]        countQ, countD;
  logic                 overflowQ, overflowD;
  logic                 syncErrQ, syncErrD;

  logic [OUT_WIDTH-1:0] sampleTrunc;
  logic                 heldLoad;
  logic                 heldClear;
  logic                 pushReq;
  logic                 syncErrSet;
  logic                 fifoFull;
  logic                 popEn;
  logic                 pushOk;
  logic                 overflowSet;

  assign i_ready     = 1'b1;
  assign sampleTrunc = i_audio[31 -: OUT_WIDTH];

  // Pairing FSM state register.
  always_ff @(posedge sclk or negedge reset_n) begin
    if (!reset_n) begin
      stateQ <= WAIT_LEFT;
    end else begin
      stateQ <= stateD;
    end
  end

  // Next state: an error always resynchronises to WAIT_LEFT; otherwise a
  // left sample opens a frame and a right sample closes it. Out-of-order
  // samples leave the state where it is.
  always_comb begin
    stateD = stateQ;
    if (i_error) begin
      stateD = WAIT_LEFT;
    end else if (i_valid) begin
      if (stateQ == WAIT_LEFT && i_is_left) begin
        stateD = WAIT_RIGHT;
      end else if (stateQ == WAIT_RIGHT && !i_is_left) begin
        stateD = WAIT_LEFT;
      end
    end
  end

  // FSM outputs: held-register control, push request and pairing errors.
  // A left arriving in WAIT_RIGHT still reloads the held register so the
  // newest left is the one paired with the next right.
  always_comb begin
    heldLoad   = 1'b0;
    heldClear  = 1'b0;
    pushReq    = 1'b0;
    syncErrSet = 1'b0;
    if (i_error) begin
      heldClear  = 1'b1;
      syncErrSet = (stateQ == WAIT_RIGHT);
    end else if (i_valid) begin
      unique case (stateQ)
        WAIT_LEFT: begin
          if (i_is_left) begin
            heldLoad = 1'b1;
          end else begin
            syncErrSet = 1'b1;
          end
        end
        WAIT_RIGHT: begin
          if (i_is_left) begin
            heldLoad   = 1'b1;
            syncErrSet = 1'b1;
          end else begin
            pushReq = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign fifoFull    = (countQ == CNT_FULL);
  assign popEn       = o_valid && o_ready;
  assign pushOk      = pushReq && (!fifoFull || popEn);
  assign overflowSet = pushReq && fifoFull && !popEn;

  always_comb begin
    countD = countQ;
    unique case ({pushOk, popEn})
      2'b10:   countD = countQ + CNT_ONE;
      2'b01:   countD = countQ - CNT_ONE;
      default: countD = countQ;
    endcase
  end

  // Sticky flags: a set event in the same cycle as a clear wins.
  assign overflowD = (overflowQ && !clear_flags) || overflowSet;
  assign syncErrD  = (syncErrQ  && !clear_flags) || syncErrSet;

  // Held left sample; cleared on a decoder error so stale data never pairs.
  always_ff @(posedge sclk or negedge reset_n) begin
    if (!reset_n) begin
      heldLeftQ <= '0;
    end else if (heldClear) begin
      heldLeftQ <= '0;
    end else if (heldLoad) begin
      heldLeftQ <= sampleTrunc;
    end
  end

  // Frame storage and pointers. The storage is reset so the outputs read
  // zero straight after reset, not whatever was left from before.
  always_ff @(posedge sclk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        memQ[i] <= '0;
      end
      wrPtrQ <= '0;
      rdPtrQ <= '0;
      countQ <= '0;
    end else begin
      if (pushOk) begin
        memQ[wrPtrQ] <= {heldLeftQ, sampleTrunc};
        wrPtrQ       <= wrPtrQ + PTR_ONE;
      end
      if (popEn) begin
        rdPtrQ <= rdPtrQ + PTR_ONE;
      end
      countQ <= countD;
    end
  end

  // Sticky status flags.
  always_ff @(posedge sclk or negedge reset_n) begin
    if (!reset_n) begin
      overflowQ <= 1'b0;
      syncErrQ  <= 1'b0;
    end else begin
      overflowQ <= overflowD;
      syncErrQ  <= syncErrD;
    end
  end

  // First-word fall-through: the head entry is driven straight from storage.
  assign o_valid    = (countQ != '0);
  assign o_left     = memQ[rdPtrQ][FW-1:OUT_WIDTH];
  assign o_right    = memQ[rdPtrQ][OUT_WIDTH-1:0];
  assign o_level    = countQ;
  assign o_overflow = overflowQ;
  assign o_sync_err = syncErrQ;

endmodule

// File: tb/tb_stereo_frame_assembler.sv
// ---------------------------------------------------------------------------
// tb_stereo_frame_assembler
//
// Directed bench for stereo_frame_assembler with OUT_WIDTH = 24 and
// FIFO_DEPTH = 4. Inputs change on the falling edge and outputs are
// checked on the falling edge, half a cycle away from the active edge.
// ---------------------------------------------------------------------------
module tb_stereo_frame_assembler;

  logic        sclk;
  logic        reset_n;
  logic        i_valid;
  logic        i_ready;
  logic        i_is_left;
  logic [31:0] i_audio;
  logic        i_error;
  logic        o_valid;
  logic        o_ready;
  logic [23:0] o_left;
  logic [23:0] o_right;
  logic [2:0]  o_level;
  logic        o_overflow;
  logic        o_sync_err;
  logic        clear_flags;

  int compareCount;
  int mismatchCount;

  stereo_frame_assembler #(
    .OUT_WIDTH (24),
    .FIFO_DEPTH(4)
  ) dut (
    .sclk       (sclk),
    .reset_n    (reset_n),
    .i_valid    (i_valid),
    .i_ready    (i_ready),
    .i_is_left  (i_is_left),
    .i_audio    (i_audio),
    .i_error    (i_error),
    .o_valid    (o_valid),
    .o_ready    (o_ready),
    .o_left     (o_left),
    .o_right    (o_right),
    .o_level    (o_level),
    .o_overflow (o_overflow),
    .o_sync_err (o_sync_err),
    .clear_flags(clear_flags)
  );

  // 10 ns bit clock.
  initial begin
    sclk = 1'b0;
    forever #5 sclk = ~sclk;
  end

  // Waits for a falling edge, then drives one cycle's worth of inputs.
  task automatic applyStimulus(input logic v, input logic isL, input logic [31:0] a,
                               input logic err, input logic clr);
    @(negedge sclk);
    i_valid     = v;
    i_is_left   = isL;
    i_audio     = a;
    i_error     = err;
    clear_flags = clr;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic clearFlags();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    reset_n     = 1'b0;
    i_valid     = 1'b0;
    i_is_left   = 1'b0;
    i_audio     = 32'h0;
    i_error     = 1'b0;
    o_ready     = 1'b0;
    clear_flags = 1'b0;
    #23;
    reset_n = 1'b1;
    @(negedge sclk);
    compareCount++; if (o_valid !== 1'b0) begin mismatchCount++; $display("[TB] FAIL reset_valid: got %b expected 0", o_valid); end
    compareCount++; if (o_level !== 3'd0) begin mismatchCount++; $display("[TB] FAIL reset_level: got %0d expected 0", o_level); end
    compareCount++; if (o_left !== 24'h0) begin mismatchCount++; $display("[TB] FAIL reset_left: got %h expected 000000", o_left); end
    compareCount++; if (o_right !== 24'h0) begin mismatchCount++; $display("[TB] FAIL reset_right: got %h expected 000000", o_right); end
    compareCount++; if (o_overflow !== 1'b0) begin mismatchCount++; $display("[TB] FAIL reset_overflow: got %b expected 0", o_overflow); end
    compareCount++; if (o_sync_err !== 1'b0) begin mismatchCount++; $display("[TB] FAIL reset_sync_err: got %b expected 0", o_sync_err); end
    compareCount++; if (i_ready !== 1'b1) begin mismatchCount++; $display("[TB] FAIL i_ready_tied: got %b expected 1", i_ready); end
  endtask

  task automatic test_basic_pairing();
    o_ready = 1'b1;
    applyStimulus(1'b1, 1'b1, 32'h12345600, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'hABCDEF00, 1'b0, 1'b0);
    idle();
    compareCount++; if (o_valid !== 1'b1) begin mismatchCount++; $display("[TB] FAIL basic_valid: got %b expected 1", o_valid); end
    compareCount++; if (o_left !== 24'h123456) begin mismatchCount++; $display("[TB] FAIL basic_left: got %h expected 123456", o_left); end
    compareCount++; if (o_right !== 24'hABCDEF) begin mismatchCount++; $display("[TB] FAIL basic_right: got %h expected abcdef", o_right); end
    compareCount++; if (o_level !== 3'd1) begin mismatchCount++; $display("[TB] FAIL basic_level1: got %0d expected 1", o_level); end
    idle();
    compareCount++; if (o_level !== 3'd0) begin mismatchCount++; $display("[TB] FAIL basic_level0: got %0d expected 0", o_level); end
    compareCount++; if (o_valid !== 1'b0) begin mismatchCount++; $display("[TB] FAIL basic_drained: got %b expected 0", o_valid); end
    compareCount++; if (o_sync_err !== 1'b0) begin mismatchCount++; $display("[TB] FAIL basic_no_sync_err: got %b expected 0", o_sync_err); end
  endtask

  task automatic test_ordering();
    o_ready = 1'b1;
    applyStimulus(1'b1, 1'b0, 32'h11111100, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'h22222200, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'h33333300, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h44444400, 1'b0, 1'b0);
    idle();
    compareCount++; if (o_valid !== 1'b1) begin mismatchCount++; $display("[TB] FAIL order_valid: got %b expected 1", o_valid); end
    compareCount++; if (o_left !== 24'h333333) begin mismatchCount++; $display("[TB] FAIL order_left: got %h expected 333333", o_left); end
    compareCount++; if (o_right !== 24'h444444) begin mismatchCount++; $display("[TB] FAIL order_right: got %h expected 444444", o_right); end
    compareCount++; if (o_sync_err !== 1'b1) begin mismatchCount++; $display("[TB] FAIL order_sync_err: got %b expected 1", o_sync_err); end
    idle();
    compareCount++; if (o_valid !== 1'b0) begin mismatchCount++; $display("[TB] FAIL order_single_frame: got %b expected 0", o_valid); end
  endtask

  task automatic test_decoder_error();
    clearFlags();
    o_ready = 1'b0;
    // Frame A sits in the FIFO before the error.
    applyStimulus(1'b1, 1'b1, 32'h0A0A0A00, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h0B0B0B00, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'h0C0C0C00, 1'b0, 1'b0);
    compareCount++; if (o_sync_err !== 1'b0) begin mismatchCount++; $display("[TB] FAIL err_flag_cleared: got %b expected 0", o_sync_err); end
    // Three error cycles; a right sample presented during the error is ignored.
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h0F0F0F00, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'h0D0D0D00, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h0E0E0E00, 1'b0, 1'b0);
    idle();
    compareCount++; if (o_level !== 3'd2) begin mismatchCount++; $display("[TB] FAIL err_level: got %0d expected 2", o_level); end
    compareCount++; if (o_sync_err !== 1'b1) begin mismatchCount++; $display("[TB] FAIL err_sync_err: got %b expected 1", o_sync_err); end
    compareCount++; if (o_left !== 24'h0A0A0A) begin mismatchCount++; $display("[TB] FAIL err_headA_left: got %h expected 0a0a0a", o_left); end
    compareCount++; if (o_right !== 24'h0B0B0B) begin mismatchCount++; $display("[TB] FAIL err_headA_right: got %h expected 0b0b0b", o_right); end
    o_ready = 1'b1;
    idle();
    compareCount++; if (o_left !== 24'h0D0D0D) begin mismatchCount++; $display("[TB] FAIL err_frame2_left: got %h expected 0d0d0d", o_left); end
    compareCount++; if (o_right !== 24'h0E0E0E) begin mismatchCount++; $display("[TB] FAIL err_frame2_right: got %h expected 0e0e0e", o_right); end
    compareCount++; if (o_level !== 3'd1) begin mismatchCount++; $display("[TB] FAIL err_level1: got %0d expected 1", o_level); end
    idle();
    compareCount++; if (o_valid !== 1'b0) begin mismatchCount++; $display("[TB] FAIL err_drained: got %b expected 0", o_valid); end
  endtask

  task automatic test_overflow();
    logic [23:0] expL;
    logic [23:0] expR;
    clearFlags();
    o_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      expL = 24'hA00000 + 24'(k);
      expR = 24'hB00000 + 24'(k);
      applyStimulus(1'b1, 1'b1, {expL, 8'h00}, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, {expR, 8'h00}, 1'b0, 1'b0);
    end
    idle();
    // Stall must keep the head stable for several cycles.
    idle();
    compareCount++; if (o_level !== 3'd4) begin mismatchCount++; $display("[TB] FAIL ovf_level: got %0d expected 4", o_level); end
    compareCount++; if (o_overflow !== 1'b1) begin mismatchCount++; $display("[TB] FAIL ovf_flag: got %b expected 1", o_overflow); end
    compareCount++; if (o_sync_err !== 1'b0) begin mismatchCount++; $display("[TB] FAIL ovf_no_sync_err: got %b expected 0", o_sync_err); end
    compareCount++; if (o_left !== 24'hA00001) begin mismatchCount++; $display("[TB] FAIL ovf_stalled_head: got %h expected a00001", o_left); end
    o_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      expL = 24'hA00000 + 24'(k);
      expR = 24'hB00000 + 24'(k);
      compareCount++; if (o_valid !== 1'b1) begin mismatchCount++; $display("[TB] FAIL ovf_valid_%0d: got %b expected 1", k, o_valid); end
      compareCount++; if (o_left !== expL) begin mismatchCount++; $display("[TB] FAIL ovf_left_%0d: got %h expected %h", k, o_left, expL); end
      compareCount++; if (o_right !== expR) begin mismatchCount++; $display("[TB] FAIL ovf_right_%0d: got %h expected %h", k, o_right, expR); end
      idle();
    end
    compareCount++; if (o_valid !== 1'b0) begin mismatchCount++; $display("[TB] FAIL ovf_frame5_absent: got %b expected 0", o_valid); end
    compareCount++; if (o_level !== 3'd0) begin mismatchCount++; $display("[TB] FAIL ovf_level0: got %0d expected 0", o_level); end
  endtask

  task automatic test_full_with_pop();
    logic [23:0] expL;
    logic [23:0] expR;
    clearFlags();
    o_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(1'b1, 1'b1, {24'hC00000 + 24'(k), 8'h00}, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, {24'hD00000 + 24'(k), 8'h00}, 1'b0, 1'b0);
    end
    applyStimulus(1'b1, 1'b1, 32'hC0000500, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'hD0000500, 1'b0, 1'b0);
    o_ready = 1'b1;
    idle();
    o_ready = 1'b0;
    compareCount++; if (o_level !== 3'd4) begin mismatchCount++; $display("[TB] FAIL fullpop_level: got %0d expected 4", o_level); end
    compareCount++; if (o_overflow !== 1'b0) begin mismatchCount++; $display("[TB] FAIL fullpop_overflow: got %b expected 0", o_overflow); end
    o_ready = 1'b1;
    for (int k = 2; k <= 5; k++) begin
      expL = 24'hC00000 + 24'(k);
      expR = 24'hD00000 + 24'(k);
      compareCount++; if (o_left !== expL) begin mismatchCount++; $display("[TB] FAIL fullpop_left_%0d: got %h expected %h", k, o_left, expL); end
      compareCount++; if (o_right !== expR) begin mismatchCount++; $display("[TB] FAIL fullpop_right_%0d: got %h expected %h", k, o_right, expR); end
      idle();
    end
    compareCount++; if (o_valid !== 1'b0) begin mismatchCount++; $display("[TB] FAIL fullpop_drained: got %b expected 0", o_valid); end
  endtask

  task automatic test_reset_mid_frame();
    o_ready = 1'b0;
    applyStimulus(1'b1, 1'b0, 32'h55555500, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'h66666600, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h77777700, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'h88888800, 1'b0, 1'b0);
    idle();
    compareCount++; if (o_valid !== 1'b1) begin mismatchCount++; $display("[TB] FAIL rst_pre_valid: got %b expected 1", o_valid); end
    compareCount++; if (o_sync_err !== 1'b1) begin mismatchCount++; $display("[TB] FAIL rst_pre_sync_err: got %b expected 1", o_sync_err); end
    // Asynchronous pulse between edges.
    #2 reset_n = 1'b0;
    #1;
    compareCount++; if (o_valid !== 1'b0) begin mismatchCount++; $display("[TB] FAIL rst_async_valid: got %b expected 0", o_valid); end
    compareCount++; if (o_level !== 3'd0) begin mismatchCount++; $display("[TB] FAIL rst_async_level: got %0d expected 0", o_level); end
    compareCount++; if (o_left !== 24'h0) begin mismatchCount++; $display("[TB] FAIL rst_async_left: got %h expected 000000", o_left); end
    compareCount++; if (o_right !== 24'h0) begin mismatchCount++; $display("[TB] FAIL rst_async_right: got %h expected 000000", o_right); end
    compareCount++; if (o_sync_err !== 1'b0) begin mismatchCount++; $display("[TB] FAIL rst_async_sync_err: got %b expected 0", o_sync_err); end
    #4 reset_n = 1'b1;
    // Held left was lost, so a lone right is a violation and produces nothing.
    o_ready = 1'b1;
    applyStimulus(1'b1, 1'b0, 32'h99999900, 1'b0, 1'b0);
    idle();
    compareCount++; if (o_valid !== 1'b0) begin mismatchCount++; $display("[TB] FAIL rst_no_frame: got %b expected 0", o_valid); end
    compareCount++; if (o_sync_err !== 1'b1) begin mismatchCount++; $display("[TB] FAIL rst_lone_right: got %b expected 1", o_sync_err); end
    clearFlags();
    idle();
    compareCount++; if (o_sync_err !== 1'b0) begin mismatchCount++; $display("[TB] FAIL clear_flags: got %b expected 0", o_sync_err); end
    // Set and clear in the same cycle: set wins.
    applyStimulus(1'b1, 1'b0, 32'hAAAAAA00, 1'b0, 1'b1);
    idle();
    compareCount++; if (o_sync_err !== 1'b1) begin mismatchCount++; $display("[TB] FAIL set_wins: got %b expected 1", o_sync_err); end
    applyStimulus(1'b1, 1'b1, 32'h13579B00, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h2468AC00, 1'b0, 1'b0);
    idle();
    compareCount++; if (o_left !== 24'h13579B) begin mismatchCount++; $display("[TB] FAIL rst_resume_left: got %h expected 13579b", o_left); end
    compareCount++; if (o_right !== 24'h2468AC) begin mismatchCount++; $display("[TB] FAIL rst_resume_right: got %h expected 2468ac", o_right); end
  endtask

  initial begin
    compareCount  = 0;
    mismatchCount = 0;
    test_reset();
    test_basic_pairing();
    test_ordering();
    test_decoder_error();
    test_overflow();
    test_full_with_pop();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
